// File: rtl/alu_seq_if.sv
// Request/result bundle between the CPU controller and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             shift_carry_out;
    logic             s;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] f;
    logic [3:0]       nzcv;

    modport master (
        output start, alu_op, a, b, shift_carry_out, s,
        input  ready, done, f, nzcv
    );

    modport slave (
        input  start, alu_op, a, b, shift_carry_out, s,
        output ready, done, f, nzcv
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ARM-style ALU with NZCV register and iterative unsigned MUL/UDIV.
// Latency 1 edge (WIDTH+1 for MUL/UDIV); ready is low while iterating and start is then ignored.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int         CW     = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic             done_q, done_d;
    logic             s_q, s_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] add_x, add_y, logic_res, alu_res;
    logic             add_cin, is_arith, c_new, v_new;
    logic [WIDTH:0]   sum;

    // Subtractions are folded into the adder as x + ~y + cin, so V uses the adder operands.
    always_comb begin
        add_x     = bus.a;
        add_y     = bus.b;
        add_cin   = 1'b0;
        is_arith  = 1'b1;
        logic_res = '0;
        case (bus.alu_op)
            4'b0000: begin is_arith = 1'b0; logic_res = bus.a & bus.b;  end
            4'b0001: begin is_arith = 1'b0; logic_res = bus.a ^ bus.b;  end
            4'b0010: begin add_y = ~bus.b; add_cin = 1'b1; end
            4'b0011: begin add_x = bus.b; add_y = ~bus.a; add_cin = 1'b1; end
            4'b0100: begin add_cin = 1'b0; end
            4'b0101: begin add_cin = nzcv_q[1]; end
            4'b0110: begin add_y = ~bus.b; add_cin = nzcv_q[1]; end
            4'b0111: begin add_x = bus.b; add_y = ~bus.a; add_cin = nzcv_q[1]; end
            4'b1000: begin is_arith = 1'b0; logic_res = bus.a; end
            4'b1010: begin add_x = bus.a + WIDTH'(4); add_y = ~bus.b; add_cin = 1'b1; end
            4'b1100: begin is_arith = 1'b0; logic_res = bus.a | bus.b;  end
            4'b1101: begin is_arith = 1'b0; logic_res = bus.b; end
            4'b1110: begin is_arith = 1'b0; logic_res = bus.a & ~bus.b; end
            4'b1111: begin is_arith = 1'b0; logic_res = ~bus.b; end
            default: begin is_arith = 1'b0; logic_res = '0; end
        endcase
        sum     = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
        alu_res = is_arith ? sum[WIDTH-1:0] : logic_res;
        c_new   = is_arith ? sum[WIDTH] : bus.shift_carry_out;
        v_new   = is_arith ? (add_x[WIDTH-1] ^ add_y[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH])
                           : nzcv_q[0];
    end

    logic [WIDTH-1:0] acc_nxt, quo_nxt, rem_nxt;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             last;

    // MUL: opa = multiplicand (shifts left), opb = multiplier (shifts right).
    // DIV: opa = dividend shifting into quotient, opb = divisor, rem = partial remainder.
    always_comb begin
        acc_nxt  = acc_q + (opb_q[0] ? opa_q : '0);
        rem_sh   = {rem_q, opa_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        quo_nxt  = {opa_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        rem_nxt  = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        last     = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        nzcv_d  = nzcv_q;
        done_d  = 1'b0;
        s_d     = s_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    s_d   = bus.s;
                    opa_d = bus.a;
                    opb_d = bus.b;
                    acc_d = '0;
                    rem_d = '0;
                    cnt_d = '0;
                    if (bus.alu_op == OP_MUL) begin
                        state_d = S_MUL;
                    end else if (bus.alu_op == OP_DIV && bus.b != '0) begin
                        state_d = S_DIV;
                    end else if (bus.alu_op == OP_DIV) begin
                        f_d    = '1;
                        done_d = 1'b1;
                        if (bus.s) nzcv_d = {1'b1, 1'b0, nzcv_q[1], 1'b1};
                    end else begin
                        f_d    = alu_res;
                        done_d = 1'b1;
                        if (bus.s) nzcv_d = {alu_res[WIDTH-1], alu_res == '0, c_new, v_new};
                    end
                end
            end
            S_MUL: begin
                acc_d = acc_nxt;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    f_d     = acc_nxt;
                    done_d  = 1'b1;
                    if (s_q) nzcv_d = {acc_nxt[WIDTH-1], acc_nxt == '0, nzcv_q[1:0]};
                end
            end
            S_DIV: begin
                opa_d = quo_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    f_d     = quo_nxt;
                    done_d  = 1'b1;
                    if (s_q) nzcv_d = {quo_nxt[WIDTH-1], quo_nxt == '0, nzcv_q[1:0]};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f_q     <= '0;
            nzcv_q  <= '0;
            done_q  <= 1'b0;
            s_q     <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            nzcv_q  <= nzcv_d;
            done_q  <= done_d;
            s_q     <= s_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.ready = (state_q == S_IDLE);
    assign bus.done  = done_q;
    assign bus.f     = f_q;
    assign bus.nzcv  = nzcv_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors checked with immediate assertions.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic sco, input logic sv);
        bus.start           = 1'b1;
        bus.alu_op          = op;
        bus.a               = av;
        bus.b               = bv;
        bus.shift_carry_out = sco;
        bus.s               = sv;
        tick();
        bus.start = 1'b0;
    endtask

    // n0 = edges already elapsed since (and including) the start edge
    task automatic wait_done(input string tag, input int n0, input int exp);
        int n;
        n = n0;
        while (bus.done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(exp));
    endtask

    initial begin
        bus.start = 1'b0; bus.alu_op = 4'h0; bus.a = '0; bus.b = '0;
        bus.shift_carry_out = 1'b0; bus.s = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_f",     64'(bus.f),     64'h0);
        chk("rst_nzcv",  64'(bus.nzcv),  64'h0);
        chk("rst_done",  64'(bus.done),  64'h0);
        chk("rst_ready", 64'(bus.ready), 64'h1);

        issue(4'b0100, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
        chk("add_f",    64'(bus.f),    64'h0);
        chk("add_nzcv", 64'(bus.nzcv), 64'h6);
        chk("add_done", 64'(bus.done), 64'h1);
        tick();
        chk("add_done_drop", 64'(bus.done), 64'h0);

        issue(4'b0010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        chk("sub_f",    64'(bus.f),    64'h8000_0000);
        chk("sub_nzcv", 64'(bus.nzcv), 64'h9);

        issue(4'b0101, 32'h1, 32'h1, 1'b0, 1'b1);
        chk("adc_f",    64'(bus.f),    64'h2);
        chk("adc_nzcv", 64'(bus.nzcv), 64'h0);
        chk("adc_done", 64'(bus.done), 64'h1);

        issue(4'b0100, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        chk("add_ovf_nzcv", 64'(bus.nzcv), 64'h7);

        // MUL, with a stray start while busy that must be ignored
        issue(4'b1001, 32'd12345, 32'd6789, 1'b0, 1'b1);
        chk("mul_ready_low", 64'(bus.ready), 64'h0);
        chk("mul_done_low",  64'(bus.done),  64'h0);
        bus.start = 1'b1; bus.alu_op = 4'b0100; bus.a = 32'h1; bus.b = 32'h1; bus.s = 1'b1;
        tick();
        tick();
        bus.start = 1'b0;
        wait_done("mul_lat", 3, 33);
        chk("mul_f",     64'(bus.f),     64'd83810205);
        chk("mul_nzcv",  64'(bus.nzcv),  64'h3);
        chk("mul_ready", 64'(bus.ready), 64'h1);
        tick();
        chk("mul_done_drop", 64'(bus.done), 64'h0);

        issue(4'b1011, 32'd100, 32'd7, 1'b0, 1'b1);
        wait_done("div_lat", 1, 33);
        chk("div_f",    64'(bus.f),    64'd14);
        chk("div_nzcv", 64'(bus.nzcv), 64'h3);

        issue(4'b1011, 32'd123, 32'd0, 1'b0, 1'b1);
        wait_done("div0_lat", 1, 1);
        chk("div0_f",    64'(bus.f),    64'hFFFF_FFFF);
        chk("div0_nzcv", 64'(bus.nzcv), 64'hB);

        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 1'b0);
        chk("and_s0_f",    64'(bus.f),    64'hF000_F000);
        chk("and_s0_nzcv", 64'(bus.nzcv), 64'hB);

        issue(4'b0010, 32'h1, 32'h2, 1'b0, 1'b1);
        chk("sub_neg_f",    64'(bus.f),    64'hFFFF_FFFF);
        chk("sub_neg_nzcv", 64'(bus.nzcv), 64'h8);

        issue(4'b0100, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
        chk("add_v_f",    64'(bus.f),    64'h8000_0000);
        chk("add_v_nzcv", 64'(bus.nzcv), 64'h9);

        issue(4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 1'b1);
        chk("and_s1_f",    64'(bus.f),    64'h0);
        chk("and_s1_nzcv", 64'(bus.nzcv), 64'h7);

        issue(4'b0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        chk("eor_f",    64'(bus.f),    64'hFFFF_FFFF);
        chk("eor_nzcv", 64'(bus.nzcv), 64'h9);

        issue(4'b0011, 32'd5, 32'd3, 1'b0, 1'b1);
        chk("rsb_f",    64'(bus.f),    64'hFFFF_FFFE);
        chk("rsb_nzcv", 64'(bus.nzcv), 64'h8);

        // Abort a MUL at iteration 10
        issue(4'b1001, 32'd3, 32'd5, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_f",     64'(bus.f),     64'h0);
        chk("abort_nzcv",  64'(bus.nzcv),  64'h0);
        chk("abort_ready", 64'(bus.ready), 64'h1);
        chk("abort_done",  64'(bus.done),  64'h0);
        tick();
        chk("abort_done2", 64'(bus.done),  64'h0);

        issue(4'b0100, 32'd2, 32'd3, 1'b0, 1'b1);
        chk("post_add_f",    64'(bus.f),    64'd5);
        chk("post_add_done", 64'(bus.done), 64'h1);
        chk("post_add_nzcv", 64'(bus.nzcv), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
